// File: rtl/regex_mem_arbiter_pkg.sv
// Shared helpers for the instruction-memory arbiter and its picker.
package regex_arb_package;

   // Width needed to hold a port index; never below 1 bit.
   function automatic int unsigned port_id_bits(input int unsigned n_ports);
      return (n_ports > 1) ? $clog2(n_ports) : 1;
   endfunction

   // Increment that sticks at the all-ones value of a 'width'-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : value + 32'd1;
   endfunction

endpackage

// File: rtl/regex_mem_arbiter_if.sv
// Fetch-side and memory-side bus between the regex cores, the arbiter and the BRAM.
interface regex_mem_arbiter_if #(
   parameter int unsigned N_PORTS           = 4,
   parameter int unsigned MEMORY_ADDR_WIDTH = 11,
   parameter int unsigned MEMORY_WIDTH      = 16
) ();
   logic [N_PORTS-1:0]                   req_valid;
   logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] req_addr;
   logic [N_PORTS-1:0]                   req_ready;
   logic [N_PORTS*MEMORY_WIDTH-1:0]      req_data;
   logic [N_PORTS-1:0]                   resp_valid;
   logic                                 mem_valid;
   logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr;
   logic                                 mem_ready;
   logic [MEMORY_WIDTH-1:0]              mem_data;

   // Arbiter view.
   modport slave (
      input  req_valid, req_addr, mem_ready, mem_data,
      output req_ready, req_data, resp_valid, mem_valid, mem_addr
   );

   // Environment view (cores + memory).
   modport master (
      output req_valid, req_addr, mem_ready, mem_data,
      input  req_ready, req_data, resp_valid, mem_valid, mem_addr
   );
endinterface

// File: rtl/regex_mem_arbiter_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module regex_rr_picker
   import regex_arb_package::*;
#(
   parameter int unsigned N_PORTS = 4,
   parameter int unsigned ID_BITS = port_id_bits(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [ID_BITS-1:0] ptr,
   output logic [N_PORTS-1:0] gnt,
   output logic [ID_BITS-1:0] gnt_id,
   output logic               any
);
   int unsigned        idx;
   logic [ID_BITS-1:0] sel;

   // Scan ptr, ptr+1, ... mod N_PORTS and take the first requester.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      sel    = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_PORTS) idx = idx - N_PORTS;
         sel = ID_BITS'(idx);
         if (!any && req[sel]) begin
            any      = 1'b1;
            gnt[sel] = 1'b1;
            gnt_id   = sel;
         end
      end
   end
endmodule

// File: rtl/regex_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency instruction BRAM among N fetch ports.
module regex_mem_arbiter
   import regex_arb_package::*;
#(
   parameter int unsigned N_PORTS           = 4,
   parameter int unsigned MEMORY_ADDR_WIDTH = 11,
   parameter int unsigned MEMORY_WIDTH      = 16,
   parameter int unsigned STALL_CNT_WIDTH   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   regex_mem_arbiter_if.slave         bus,
   input  logic                       stall_clear,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
);
   localparam int unsigned ID_BITS = port_id_bits(N_PORTS);

   logic [ID_BITS-1:0]         rr_ptr;
   logic [N_PORTS-1:0]         gnt_oh;
   logic [ID_BITS-1:0]         gnt_id;
   logic                       gnt_any;
   logic                       gnt_v_q;
   logic [ID_BITS-1:0]         gnt_id_q;
   logic [MEMORY_WIDTH-1:0]    hold [N_PORTS];
   logic [STALL_CNT_WIDTH-1:0] stall_q;
   logic                       contention;

   // Masking requests with mem_ready makes "no grant while memory busy" fall out of the picker.
   regex_rr_picker #(
      .N_PORTS (N_PORTS),
      .ID_BITS (ID_BITS)
   ) u_picker (
      .req    (bus.req_valid & {N_PORTS{bus.mem_ready}}),
      .ptr    (rr_ptr),
      .gnt    (gnt_oh),
      .gnt_id (gnt_id),
      .any    (gnt_any)
   );

   assign bus.req_ready = gnt_oh;
   assign bus.mem_valid = gnt_any;
   assign contention    = |(bus.req_valid & ~gnt_oh);
   assign stall_count   = stall_q;

   // Memory address mux and the return path for the previous cycle's grant.
   always_comb begin
      bus.mem_addr   = '0;
      bus.resp_valid = '0;
      bus.req_data   = '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
         if (gnt_oh[p]) bus.mem_addr = bus.req_addr[p*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
         if (gnt_v_q && gnt_id_q == ID_BITS'(p)) begin
            bus.resp_valid[p]                        = 1'b1;
            bus.req_data[p*MEMORY_WIDTH +: MEMORY_WIDTH] = bus.mem_data;
         end else begin
            bus.req_data[p*MEMORY_WIDTH +: MEMORY_WIDTH] = hold[p];
         end
      end
   end

   // Pointer, grant pipeline and per-port hold registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         gnt_v_q  <= 1'b0;
         gnt_id_q <= '0;
         for (int unsigned p = 0; p < N_PORTS; p++) hold[p] <= '0;
      end else begin
         if (gnt_any) rr_ptr <= (gnt_id == ID_BITS'(N_PORTS - 1)) ? '0 : gnt_id + 1'b1;
         gnt_v_q  <= gnt_any;
         gnt_id_q <= gnt_id;
         for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (gnt_v_q && gnt_id_q == ID_BITS'(p)) hold[p] <= bus.mem_data;
         end
      end
   end

   // Saturating contention counter; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (stall_clear) begin
         stall_q <= '0;
      end else if (contention) begin
         stall_q <= STALL_CNT_WIDTH'(sat_inc(32'(stall_q), STALL_CNT_WIDTH));
      end
   end
endmodule

// File: tb/tb_regex_mem_arbiter.sv
// Directed, table-driven bench for regex_mem_arbiter (4 ports, 4-bit stall counter).
module tb_regex_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       stall_clear;
   logic [3:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   regex_mem_arbiter_if #(
      .N_PORTS           (4),
      .MEMORY_ADDR_WIDTH (11),
      .MEMORY_WIDTH      (16)
   ) bus ();

   regex_mem_arbiter #(
      .N_PORTS           (4),
      .MEMORY_ADDR_WIDTH (11),
      .MEMORY_WIDTH      (16),
      .STALL_CNT_WIDTH   (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .stall_clear (stall_clear),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic        mr;
      logic [15:0] md;
      logic        clr;
      logic [3:0]  e_ready;
      logic        e_mval;
      logic [10:0] e_addr;
      logic [3:0]  e_resp;
      logic [63:0] e_data;
      logic [3:0]  e_stall;
   } vec_t;

   vec_t        vecs [21];
   logic [10:0] port_addr [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      port_addr[0] = 11'h100;
      port_addr[1] = 11'h211;
      port_addr[2] = 11'h005;
      port_addr[3] = 11'h7FF;

      //          valid    mr  md        clr  ready    mv  addr     resp     data                     stall
      vecs[0]  = '{4'b0100, 1, 16'h0000, 0, 4'b0100, 1, 11'h005, 4'b0000, 64'h0000_0000_0000_0000, 4'd0};
      vecs[1]  = '{4'b0000, 1, 16'hABCD, 0, 4'b0000, 0, 11'h000, 4'b0100, 64'h0000_ABCD_0000_0000, 4'd0};
      vecs[2]  = '{4'b0000, 1, 16'h1111, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'h0000_ABCD_0000_0000, 4'd0};
      vecs[3]  = '{4'b0010, 1, 16'h2222, 0, 4'b0010, 1, 11'h211, 4'b0000, 64'h0000_ABCD_0000_0000, 4'd0};
      vecs[4]  = '{4'b1010, 1, 16'h3333, 0, 4'b1000, 1, 11'h7FF, 4'b0010, 64'h0000_ABCD_3333_0000, 4'd0};
      vecs[5]  = '{4'b0010, 1, 16'h4444, 0, 4'b0010, 1, 11'h211, 4'b1000, 64'h4444_ABCD_3333_0000, 4'd1};
      vecs[6]  = '{4'b0000, 1, 16'h5555, 1, 4'b0000, 0, 11'h000, 4'b0010, 64'h4444_ABCD_5555_0000, 4'd1};
      vecs[7]  = '{4'b0001, 0, 16'h6666, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'h4444_ABCD_5555_0000, 4'd0};
      vecs[8]  = '{4'b0001, 0, 16'h6666, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'h4444_ABCD_5555_0000, 4'd1};
      vecs[9]  = '{4'b0001, 0, 16'h6666, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'h4444_ABCD_5555_0000, 4'd2};
      vecs[10] = '{4'b0001, 0, 16'h6666, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'h4444_ABCD_5555_0000, 4'd3};
      vecs[11] = '{4'b0001, 0, 16'h6666, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'h4444_ABCD_5555_0000, 4'd4};
      vecs[12] = '{4'b0001, 1, 16'h7777, 0, 4'b0001, 1, 11'h100, 4'b0000, 64'h4444_ABCD_5555_0000, 4'd5};
      vecs[13] = '{4'b1111, 1, 16'h8888, 1, 4'b0010, 1, 11'h211, 4'b0001, 64'h4444_ABCD_5555_8888, 4'd5};
      vecs[14] = '{4'b1111, 1, 16'h9999, 0, 4'b0100, 1, 11'h005, 4'b0010, 64'h4444_ABCD_9999_8888, 4'd0};
      vecs[15] = '{4'b1111, 1, 16'hAAAA, 0, 4'b1000, 1, 11'h7FF, 4'b0100, 64'h4444_AAAA_9999_8888, 4'd1};
      vecs[16] = '{4'b1111, 1, 16'hBBBB, 0, 4'b0001, 1, 11'h100, 4'b1000, 64'hBBBB_AAAA_9999_8888, 4'd2};
      vecs[17] = '{4'b0000, 1, 16'hCCCC, 0, 4'b0000, 0, 11'h000, 4'b0001, 64'hBBBB_AAAA_9999_CCCC, 4'd3};
      vecs[18] = '{4'b0100, 1, 16'h0000, 0, 4'b0100, 1, 11'h005, 4'b0000, 64'hBBBB_AAAA_9999_CCCC, 4'd3};
      vecs[19] = '{4'b0000, 0, 16'hDDDD, 0, 4'b0000, 0, 11'h000, 4'b0100, 64'hBBBB_DDDD_9999_CCCC, 4'd3};
      vecs[20] = '{4'b0000, 1, 16'h0000, 0, 4'b0000, 0, 11'h000, 4'b0000, 64'hBBBB_DDDD_9999_CCCC, 4'd3};

      // Reset state; combinational grant still follows inputs while in reset.
      rst_n         = 1'b0;
      stall_clear   = 1'b0;
      bus.req_addr  = {port_addr[3], port_addr[2], port_addr[1], port_addr[0]};
      bus.req_valid = 4'b0100;
      bus.mem_ready = 1'b1;
      bus.mem_data  = 16'h0000;
      @(negedge clk);
      check("rst.resp", 64'(bus.resp_valid), 64'h0);
      check("rst.data", bus.req_data, 64'h0);
      check("rst.stall", 64'(stall_count), 64'h0);
      check("rst.ready_comb", 64'(bus.req_ready), 64'h4);
      bus.req_valid = 4'b0000;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 21; i++) begin
         bus.req_valid = vecs[i].valid;
         bus.mem_ready = vecs[i].mr;
         bus.mem_data  = vecs[i].md;
         stall_clear   = vecs[i].clr;
         @(negedge clk);
         check($sformatf("v%0d.ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
         check($sformatf("v%0d.mem_valid", i), 64'(bus.mem_valid), 64'(vecs[i].e_mval));
         check($sformatf("v%0d.mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].e_addr));
         check($sformatf("v%0d.resp", i), 64'(bus.resp_valid), 64'(vecs[i].e_resp));
         check($sformatf("v%0d.data", i), bus.req_data, vecs[i].e_data);
         check($sformatf("v%0d.stall", i), 64'(stall_count), 64'(vecs[i].e_stall));
         @(posedge clk); #1;
      end

      // Reset asserted the cycle after a grant to port 1 (pointer is 3 here).
      stall_clear   = 1'b0;
      bus.req_valid = 4'b0010;
      bus.mem_ready = 1'b1;
      bus.mem_data  = 16'h5A5A;
      @(negedge clk);
      check("mid.ready", 64'(bus.req_ready), 64'h2);
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      check("mid.resp_before", 64'(bus.resp_valid), 64'h2);
      check("mid.data_before", 64'(bus.req_data[31:16]), 64'h5A5A);
      rst_n = 1'b0;
      #1;
      check("mid.resp_after", 64'(bus.resp_valid), 64'h0);
      check("mid.data_after", bus.req_data, 64'h0);
      check("mid.stall_after", 64'(stall_count), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // All ports requesting after reset: rotation from port 0, saturation, then clear.
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 23; k++) begin
         logic [3:0] exp_stall;
         int         prev;
         bus.mem_data = 16'h1000 + 16'(k);
         stall_clear  = (k == 20);
         exp_stall = (k <= 15) ? 4'(k) : ((k <= 20) ? 4'd15 : 4'(k - 21));
         @(negedge clk);
         check($sformatf("rr%0d.ready", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
         check($sformatf("rr%0d.mem_addr", k), 64'(bus.mem_addr), 64'(port_addr[k % 4]));
         check($sformatf("rr%0d.stall", k), 64'(stall_count), 64'(exp_stall));
         if (k == 0) begin
            check("rr0.resp", 64'(bus.resp_valid), 64'h0);
         end else begin
            prev = (k - 1) % 4;
            check($sformatf("rr%0d.resp", k), 64'(bus.resp_valid), 64'(4'b0001 << prev));
            check($sformatf("rr%0d.data", k), 64'(bus.req_data[prev*16 +: 16]), 64'(16'h1000 + 16'(k)));
         end
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
